// File: rtl/timestamp_streamer_if.sv
// Host pipe bundle carrying timestamp beats out of timestamp_streamer.
// Handshake: a beat transfers on a rising clk edge where pipeTVALID and
// pipeTREADY are both 1. Once the source raises pipeTVALID it keeps
// pipeTVALID, pipeTDATA and pipeTLAST unchanged until that transfer. The
// sink may change pipeTREADY freely. pipeTLAST flags the final (trailer)
// beat of a run.
interface timestamp_streamer_if;
  logic [31:0] pipeTDATA;
  logic        pipeTVALID;
  logic        pipeTREADY;
  logic        pipeTLAST;

  modport master (output pipeTDATA, output pipeTVALID, output pipeTLAST,
                  input pipeTREADY);
  modport slave  (input pipeTDATA, input pipeTVALID, input pipeTLAST,
                  output pipeTREADY);
endinterface

// File: rtl/timestamp_streamer.sv
// Profiling timestamp streamer: while a run is active, "save" commands
// capture a free-running 64-bit timer into a FIFO. Each entry streams out as
// two 32-bit beats (low word, then high word). A trailer beat carrying the
// overflow count closes the run.
// TIMER_LOAD is the value the timer takes on entry to RUN. It is 0 in normal
// use. A nonzero value lets the 64-bit wrap be reached without running for
// 2^64 cycles.
module timestamp_streamer #(
  parameter int          DEPTH      = 16,
  parameter logic [63:0] TIMER_LOAD = 64'd0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [3:0]                  command,
  output logic                        done,
  output logic [1:0]                  dbg_state,
  timestamp_streamer_if.master        pipe
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [3:0]  CMD_SAVE   = 4'h1;
  localparam logic [3:0]  CMD_FINISH = 4'h2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DRAIN   = 2'd2,
    S_TRAILER = 2'd3
  } state_t;

  state_t state, state_next;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          hi_sel;        // 0: low word of head is on the bus, 1: high word
  logic [63:0]   timer;
  logic [15:0]   ovf_count;
  logic [63:0]   head;

  logic stream_active, stream_beat, pop, push_req, push, push_reject;

  assign head          = mem[rd_ptr];
  assign stream_active = ((state == S_RUN) || (state == S_DRAIN)) && (count != '0);
  assign stream_beat   = stream_active && pipe.pipeTREADY;
  assign pop           = stream_beat && hi_sel;
  assign push_req      = (state == S_RUN) && (command == CMD_SAVE);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push          = push_req && ((count != FULL_CNT) || pop);
  assign push_reject   = push_req && !push;

  assign done      = (state == S_IDLE);
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode and pipe outputs (data and last are zero when not valid).
  always_comb begin
    state_next      = state;
    pipe.pipeTVALID = 1'b0;
    pipe.pipeTLAST  = 1'b0;
    pipe.pipeTDATA  = 32'd0;
    case (state)
      S_IDLE:    if (start) state_next = S_RUN;
      S_RUN:     if (command == CMD_FINISH) state_next = S_DRAIN;
      S_DRAIN:   if ((count == '0) && !hi_sel) state_next = S_TRAILER;
      S_TRAILER: if (pipe.pipeTREADY) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    if (state == S_TRAILER) begin
      pipe.pipeTVALID = 1'b1;
      pipe.pipeTLAST  = 1'b1;
      pipe.pipeTDATA  = {16'hFFFF, ovf_count};
    end else if (stream_active) begin
      pipe.pipeTVALID = 1'b1;
      pipe.pipeTDATA  = hi_sel ? head[63:32] : head[31:0];
    end
  end

  // Timer, FIFO pointers, beat select and overflow counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      hi_sel    <= 1'b0;
      timer     <= 64'd0;
      ovf_count <= 16'd0;
    end else begin
      if ((state == S_IDLE) && start) begin
        timer     <= TIMER_LOAD;
        ovf_count <= 16'd0;
      end else if ((state == S_RUN) || (state == S_DRAIN)) begin
        timer <= timer + 64'd1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (stream_beat) hi_sel <= ~hi_sel;
      if (push_reject && (ovf_count != 16'hFFFF)) ovf_count <= ovf_count + 16'd1;
    end
  end

  // FIFO storage; contents are only observed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= timer;
  end

endmodule

// File: tb/tb_timestamp_streamer.sv
// Bench for timestamp_streamer: an abstract run model (phase, entry queue,
// timer, overflow count) checked every cycle, plus literal beat lists for
// each directed scenario.
module tb_timestamp_streamer;
  localparam int          DEPTH  = 4;
  localparam logic [63:0] W_LOAD = 64'hFFFF_FFFF_FFFF_FFFD;

  logic       clk = 1'b0;
  logic       rst, start, w_start;
  logic [3:0] command, w_command;
  logic       done, w_done;
  logic [1:0] dbg_state, w_dbg_state;

  timestamp_streamer_if bus();
  timestamp_streamer_if w_bus();

  int checks = 0;
  int errors = 0;

  // Clock and reset-free clock generation.
  always #5 clk = ~clk;

  timestamp_streamer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .command(command),
    .done(done), .dbg_state(dbg_state), .pipe(bus)
  );

  timestamp_streamer #(.DEPTH(DEPTH), .TIMER_LOAD(W_LOAD)) w_dut (
    .clk(clk), .rst(rst), .start(w_start), .command(w_command),
    .done(w_done), .dbg_state(w_dbg_state), .pipe(w_bus)
  );

  // Abstract model state.
  int          m_phase = 0;   // 0 idle, 1 run, 2 drain, 3 trailer
  logic [63:0] m_timer = '0;
  logic [63:0] m_q[$];
  logic        m_half = 1'b0; // next beat of the head entry is its high word
  int          m_ovf = 0;
  bit          model_init = 0;
  bit          prev_hold = 0;
  logic [33:0] prev_out = '0;

  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  logic [32:0] w_got[$];

  // Compare process: check outputs against the model, then advance the model.
  always @(negedge clk) begin : compare
    logic        exp_valid;
    logic [34:0] exp_out, act_out;
    logic [63:0] hd;
    bit          beat, pop_now, drained;
    act_out   = {done, bus.pipeTVALID, bus.pipeTLAST, bus.pipeTDATA};
    exp_valid = (((m_phase == 1) || (m_phase == 2)) && (m_q.size() > 0)) || (m_phase == 3);
    hd        = (m_q.size() > 0) ? m_q[0] : 64'd0;
    if (m_phase == 3)   exp_out = {1'b0, 1'b1, 1'b1, 16'hFFFF, m_ovf[15:0]};
    else if (exp_valid) exp_out = {1'b0, 1'b1, 1'b0, (m_half ? hd[63:32] : hd[31:0])};
    else                exp_out = {(m_phase == 0), 34'd0};
    if (model_init) begin
      checks++;
      if (act_out !== exp_out) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got done/valid/last/data=%h required %h",
                 $time, act_out, exp_out);
      end
      if (prev_hold) begin
        checks++;
        if (act_out[33:0] !== prev_out) begin
          errors++;
          $display("FAIL hold_stable t=%0t got valid/last/data=%h required %h",
                   $time, act_out[33:0], prev_out);
        end
      end
    end
    if (!rst && (bus.pipeTVALID === 1'b1) && (bus.pipeTREADY === 1'b1))
      got_q.push_back({bus.pipeTLAST, bus.pipeTDATA});
    prev_hold = !rst && model_init && (bus.pipeTVALID === 1'b1) && (bus.pipeTREADY !== 1'b1);
    prev_out  = act_out[33:0];

    if (rst) begin
      m_phase = 0; m_q.delete(); m_half = 1'b0; m_timer = '0; m_ovf = 0;
      model_init = 1;
    end else begin
      case (m_phase)
        0: if (start) begin m_phase = 1; m_timer = 64'd0; m_ovf = 0; end
        1, 2: begin
          drained = (m_q.size() == 0);
          beat    = exp_valid && bus.pipeTREADY;
          pop_now = beat && m_half;
          if (beat) m_half = !m_half;
          if (pop_now) void'(m_q.pop_front());
          if ((m_phase == 1) && (command == 4'h1)) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_timer);
            else if (m_ovf < 65535) m_ovf++;
          end
          if ((m_phase == 1) && (command == 4'h2)) m_phase = 2;
          else if ((m_phase == 2) && drained)      m_phase = 3;
          m_timer = m_timer + 64'd1;
        end
        default: if (bus.pipeTREADY) m_phase = 0;
      endcase
    end
  end

  // Beat capture for the wrap instance.
  always @(negedge clk) begin
    if (!rst && (w_bus.pipeTVALID === 1'b1) && (w_bus.pipeTREADY === 1'b1))
      w_got.push_back({w_bus.pipeTLAST, w_bus.pipeTDATA});
  end

  // Driver tasks.
  task automatic step(input logic s, input logic [3:0] c, input logic r);
    start = s; command = c; bus.pipeTREADY = r;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string name, input int max, input logic [15:0] rpat,
                           input logic [3:0] c);
    bit ok = 0;
    for (int i = 0; (i < max) && !ok; i++) begin
      start = 1'b0; command = c; bus.pipeTREADY = rpat[i % 16];
      @(posedge clk); #1;
      if (done) ok = 1;
    end
    command = 4'h0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_done_timeout got done=%b required 1 within %0d cycles", name, done, max);
    end
  endtask

  task automatic check_val(input string name, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  task automatic push_entry(input logic [63:0] v);
    exp_q.push_back({1'b0, v[31:0]});
    exp_q.push_back({1'b0, v[63:32]});
  endtask

  task automatic push_trailer(input logic [15:0] ovf);
    exp_q.push_back({1'b1, 16'hFFFF, ovf});
  endtask

  // Scoreboard: captured beats against the hand-written list.
  task automatic check_run(input string name);
    logic [32:0] g;
    check_val({name, "_beat_count"}, 33'(got_q.size()), 33'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 33'h0;
      check_val($sformatf("%s_beat%0d", name, i), g, exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic basic_run(input string name);
    got_q.delete();
    step(1'b1, 4'h0, 1'b1);
    for (int i = 0; i <= 10; i++)
      step(1'b0, (i == 5 || i == 9) ? 4'h1 : ((i == 10) ? 4'h2 : 4'h0), 1'b1);
    wait_done(name, 40, 16'hFFFF, 4'h0);
    push_entry(64'd5); push_entry(64'd9); push_trailer(16'h0000);
    check_run(name);
  endtask

  initial begin
    bit ok;
    rst = 1'b1; start = 1'b0; command = 4'h0; bus.pipeTREADY = 1'b0;
    w_start = 1'b0; w_command = 4'h0; w_bus.pipeTREADY = 1'b1;
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    rst = 1'b0;
    check_val("reset_done",  {32'd0, done}, 33'd1);
    check_val("reset_valid", {32'd0, bus.pipeTVALID}, 33'd0);
    check_val("reset_last",  {32'd0, bus.pipeTLAST}, 33'd0);
    check_val("reset_data",  {1'b0, bus.pipeTDATA}, 33'd0);
    step(1'b0, 4'h0, 1'b1);

    basic_run("basic");

    // Backpressure: three entries held for ten stalled cycles, a stray start
    // mid-run, then a patterned ready while save commands arrive in DRAIN.
    step(1'b1, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    for (int i = 1; i <= 3; i++) step(1'b0, 4'h1, 1'b0);
    for (int i = 0; i < 10; i++) step((i == 4), 4'h0, 1'b0);
    step(1'b0, 4'h2, 1'b0);
    wait_done("backpressure", 60, 16'b1011_0010_1101_1001, 4'h1);
    push_entry(64'd1); push_entry(64'd2); push_entry(64'd3); push_trailer(16'h0000);
    check_run("backpressure");

    // Overflow: seven saves into a four-entry FIFO with no drain.
    step(1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 4'h1, 1'b0);
    step(1'b0, 4'h2, 1'b0);
    wait_done("overflow", 60, 16'hFFFF, 4'h0);
    for (int i = 0; i < 4; i++) push_entry(64'(i));
    push_trailer(16'h0003);
    check_run("overflow");

    // Full FIFO with a save in the high-word handshake cycle.
    step(1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'h1, 1'b0);
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h1, 1'b1);
    step(1'b0, 4'h2, 1'b0);
    wait_done("full_pop", 60, 16'hFFFF, 4'h0);
    for (int i = 0; i < 4; i++) push_entry(64'(i));
    push_entry(64'd5);
    push_trailer(16'h0000);
    check_run("full_pop");

    // Reset while a beat is on the bus, then a fresh run.
    step(1'b1, 4'h0, 1'b0);
    step(1'b0, 4'h1, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    check_val("midbeat_valid_before", {32'd0, bus.pipeTVALID}, 33'd1);
    rst = 1'b1;
    step(1'b0, 4'h0, 1'b1);
    rst = 1'b0;
    check_val("midbeat_valid_after", {32'd0, bus.pipeTVALID}, 33'd0);
    check_val("midbeat_done_after",  {32'd0, done}, 33'd1);
    check_val("midbeat_no_beats",    33'(got_q.size()), 33'd0);
    step(1'b0, 4'h0, 1'b1);
    basic_run("after_reset");

    // Timer wrap on the second instance: saves at timer 2^64-1 and 0.
    w_got.delete();
    w_start = 1'b1; @(posedge clk); #1;
    w_start = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      w_command = (i == 2 || i == 3) ? 4'h1 : ((i == 4) ? 4'h2 : 4'h0);
      @(posedge clk); #1;
    end
    w_command = 4'h0;
    ok = 0;
    for (int i = 0; (i < 30) && !ok; i++) begin
      @(posedge clk); #1;
      if (w_done) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wrap_done_timeout got done=%b required 1 within 30 cycles", w_done);
    end
    got_q = w_got;
    push_entry(64'hFFFF_FFFF_FFFF_FFFF); push_entry(64'd0); push_trailer(16'h0000);
    check_run("wrap");

    step(1'b0, 4'h0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout got running at %0t required finished", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timestamp_streamer.md
TIMESTAMP_STREAMER -- requirements
Module: timestamp_streamer

Interface
REQ-001 Parameter DEPTH, default 16, timestamp FIFO entries; power of two, 2..256.
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  single-cycle pulse; begins a profiling run when idle.
REQ-005 command  in  4  per-cycle command: 0x0 NOP, 0x1 save timestamp, 0x2 finish; other codes ignored.
REQ-006 done  out  1  high exactly when state is IDLE.
REQ-007 pipeTDATA  out  32  AXI4-Stream source data toward the host pipe.
REQ-008 pipeTVALID  out  1  AXI4-Stream source valid.
REQ-009 pipeTREADY  in  1  AXI4-Stream sink ready.
REQ-010 pipeTLAST  out  1  marks the trailer beat, the final beat of a run.

Function
REQ-011 The block SHALL implement the states IDLE, RUN, DRAIN and TRAILER.
REQ-012 IDLE->RUN on start=1; start SHALL be ignored in every other state.
REQ-013 On entry to RUN the block SHALL clear the 64-bit timer to 0, so the first RUN cycle reads timer=0.
REQ-014 Timer SHALL increment by 1 every cycle in RUN and DRAIN, wrap modulo 2^64, and hold in IDLE and TRAILER.
REQ-015 In RUN, command=0x1 SHALL push the timer value of that same cycle into the FIFO.
REQ-016 A push SHALL be accepted if the FIFO is not full, or if a pop occurs in the same cycle.
REQ-017 A rejected push SHALL increment a 16-bit overflow count that saturates at 0xFFFF.
REQ-018 RUN->DRAIN on command=0x2, with no push that cycle; commands SHALL be ignored in DRAIN, TRAILER and IDLE.
REQ-019 Streaming SHALL run concurrently in RUN and DRAIN: each FIFO entry is sent as two beats, low word [31:0] then high word [63:32].
REQ-020 Handshake: a beat completes on a cycle with pipeTVALID=1 and pipeTREADY=1.
REQ-021 Once pipeTVALID is asserted, pipeTVALID, pipeTDATA and pipeTLAST SHALL hold unchanged until that beat completes.
REQ-022 Completion of the high-word beat SHALL pop the FIFO head.
REQ-023 pipeTVALID SHALL be high in RUN/DRAIN whenever the FIFO is non-empty, and low when the FIFO is empty.
REQ-024 DRAIN->TRAILER on the cycle after the FIFO is empty and no beat is outstanding.
REQ-025 In TRAILER the block SHALL drive pipeTVALID=1, pipeTLAST=1 and pipeTDATA={16'hFFFF, overflow_count}.
REQ-026 TRAILER->IDLE when the trailer beat completes; done SHALL rise the following cycle.
REQ-027 When pipeTVALID=0, pipeTDATA and pipeTLAST SHALL be 0.
REQ-028 With pipeTREADY held high, the FIFO SHALL drain one entry per two cycles.
REQ-029 Entering RUN SHALL clear the overflow count; the FIFO is already empty at that point.

Reset
REQ-030 While rst=1 at a clock edge the block SHALL go to IDLE, with the FIFO empty, pointers 0, beat select at the low word, timer 0 and overflow count 0.
REQ-031 Reset values of the outputs SHALL be done=1, pipeTVALID=0, pipeTLAST=0 and pipeTDATA=0.
REQ-032 Reset asserted mid-run or mid-beat SHALL discard pending data without completing the beat; the block SHALL then respond to start normally.

Verification
REQ-033 Basic run: start at cycle 0, command=0x1 at RUN cycles 5 and 9, then 0x2, pipeTREADY=1 -> beats 0x5, 0x0, 0x9, 0x0, then 0xFFFF0000 with TLAST=1, then done=1.
REQ-034 Backpressure: pipeTREADY=0 for 10 cycles with data pending -> TVALID stays high, TDATA stays stable, no beat is lost or duplicated.
REQ-035 Overflow: DEPTH=4, pipeTREADY=0, seven 0x1 commands, then 0x2, then ready=1 -> 4 entries (8 beats) sent, trailer 0xFFFF0003.
REQ-036 Full with simultaneous pop: FIFO full, 0x1 issued in the high-word handshake cycle -> push accepted, overflow count unchanged.
REQ-037 Timer wrap: timer forced to 0xFFFFFFFF_FFFFFFFF, 0x1 on that cycle and on the next cycle -> entries 0xFFFFFFFF_FFFFFFFF then 0x0.
REQ-038 Reset mid-beat: rst during TVALID=1 -> next cycle TVALID=0 and done=1; a fresh run then behaves as in REQ-033.
